// File: rtl/univ_shift_reg.sv
// Purpose : WIDTH-bit universal shift register with hold, load, shift, rotate, clear, invert and a word counter.
// Latency : every operation is visible on q/q0/sout/cnt/word_done/par one cycle after the sampling edge.
// Backpressure: none; en=0 freezes all state and suppresses word_done.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset (beats en/mode)
//   en         operation enable; 0 holds everything
//   mode       3-bit operation select (see MODE_* below)
//   d          parallel load data
//   sin        serial input for shl/shr
//   q / q0     register contents and its registered complement
//   sout       last bit shifted or rotated out
//   cnt        consecutive shift/rotate ops in the current word
//   word_done  one-cycle pulse when the WIDTH-th consecutive shift/rotate completes
//   par        even parity of q
//
// Optional feature: define UNIV_SHIFT_REG_PARITY_EN to register par = ^q.
// Without it par is tied to 0 and no parity logic is built.

module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q0,
  output logic             sout,
  output logic [CW-1:0]    cnt,
  output logic             word_done,
  output logic             par
);

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_LOAD  = 3'b001;
  localparam logic [2:0] MODE_SHL   = 3'b010;
  localparam logic [2:0] MODE_SHR   = 3'b011;
  localparam logic [2:0] MODE_ROL   = 3'b100;
  localparam logic [2:0] MODE_ROR   = 3'b101;
  localparam logic [2:0] MODE_CLEAR = 3'b110;
  localparam logic [2:0] MODE_INV   = 3'b111;

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] q0_q;
  logic             sout_q, sout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             shift_op;

  // Next-state logic for data, serial out and the word counter.
  always_comb begin
    q_d      = q_q;
    sout_d   = sout_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    shift_op = 1'b0;
    if (en) begin
      case (mode)
        MODE_HOLD: ;
        MODE_LOAD: begin
          q_d   = d;
          cnt_d = '0;
        end
        MODE_SHL: begin
          q_d      = {q_q[WIDTH-2:0], sin};
          sout_d   = q_q[WIDTH-1];
          shift_op = 1'b1;
        end
        MODE_SHR: begin
          q_d      = {sin, q_q[WIDTH-1:1]};
          sout_d   = q_q[0];
          shift_op = 1'b1;
        end
        MODE_ROL: begin
          q_d      = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          sout_d   = q_q[WIDTH-1];
          shift_op = 1'b1;
        end
        MODE_ROR: begin
          q_d      = {q_q[0], q_q[WIDTH-1:1]};
          sout_d   = q_q[0];
          shift_op = 1'b1;
        end
        MODE_CLEAR: begin
          q_d   = '0;
          cnt_d = '0;
        end
        MODE_INV: q_d = ~q_q;
        default: ;
      endcase
    end
    // Any mix of shift and rotate directions counts toward the same word.
    if (shift_op) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q    <= '0;
      q0_q   <= '1;
      sout_q <= 1'b0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      // Complement is registered from the same next-state so it can never diverge from q.
      q0_q   <= ~q_d;
      sout_q <= sout_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

`ifdef UNIV_SHIFT_REG_PARITY_EN
  logic par_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      par_q <= 1'b0;
    end else begin
      par_q <= ^q_d;
    end
  end

  assign par = par_q;
`else
  assign par = 1'b0;
`endif

  assign q         = q_q;
  assign q0        = q0_q;
  assign sout      = sout_q;
  assign cnt       = cnt_q;
  assign word_done = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
module tb_univ_shift_reg;

  localparam int WIDTH = 8;
  localparam int CW    = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q0;
  logic             sout;
  logic [CW-1:0]    cnt;
  logic             word_done;
  logic             par;

  int checks = 0;
  int errors = 0;

`ifdef UNIV_SHIFT_REG_PARITY_EN
  localparam logic PAR_ON = 1'b1;
`else
  localparam logic PAR_ON = 1'b0;
`endif

  univ_shift_reg #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .mode      (mode),
    .d         (d),
    .sin       (sin),
    .q         (q),
    .q0        (q0),
    .sout      (sout),
    .cnt       (cnt),
    .word_done (word_done),
    .par       (par)
  );

  always #5 clk = ~clk;

  // Apply one operation and settle just after the edge.
  task automatic op(input logic e, input logic [2:0] m, input logic [7:0] dv, input logic s);
    en = e; mode = m; d = dv; sin = s;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    op(1'b1, 3'b001, 8'hA5, 1'b0);
    reset = 1'b0;
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q got %h exp 00", q); end
    checks++; if (q0 !== 8'hFF) begin errors++; $display("FAIL reset_q0 got %h exp FF", q0); end
    checks++; if (sout !== 1'b0) begin errors++; $display("FAIL reset_sout got %b exp 0", sout); end
    checks++; if (cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", cnt); end
    checks++; if (word_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", word_done); end
    checks++; if (par !== 1'b0) begin errors++; $display("FAIL reset_par got %b exp 0", par); end
  endtask

  task automatic test_load_enable;
    op(1'b1, 3'b001, 8'h3C, 1'b0);
    checks++; if (q !== 8'h3C) begin errors++; $display("FAIL load_q got %h exp 3C", q); end
    checks++; if (q0 !== 8'hC3) begin errors++; $display("FAIL load_q0 got %h exp C3", q0); end
    for (int i = 0; i < 3; i++) begin
      op(1'b0, 3'b110, 8'h00, 1'b0);
      checks++; if (q !== 8'h3C) begin errors++; $display("FAIL en0_clear_q[%0d] got %h exp 3C", i, q); end
    end
    // en=0 with a shift mode must not move data, sout or cnt
    op(1'b0, 3'b010, 8'h00, 1'b1);
    checks++; if ({q, sout, cnt} !== {8'h3C, 1'b0, 3'd0})
      begin errors++; $display("FAIL en0_shl got q=%h sout=%b cnt=%0d exp 3C/0/0", q, sout, cnt); end
    op(1'b1, 3'b000, 8'hFF, 1'b1);
    checks++; if ({q, q0, cnt} !== {8'h3C, 8'hC3, 3'd0})
      begin errors++; $display("FAIL hold got q=%h q0=%h cnt=%0d exp 3C/C3/0", q, q0, cnt); end
  endtask

  task automatic test_serial_word;
    logic [7:0] pat;
    pat = 8'b10110010;
    op(1'b1, 3'b001, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) begin
      op(1'b1, 3'b010, 8'h00, pat[7-i]);
      checks++; if (cnt !== 3'((i + 1) % 8))
        begin errors++; $display("FAIL serial_cnt[%0d] got %0d exp %0d", i, cnt, (i + 1) % 8); end
      checks++; if (word_done !== (i == 7))
        begin errors++; $display("FAIL serial_done[%0d] got %b exp %b", i, word_done, (i == 7)); end
    end
    checks++; if (q !== 8'hB2) begin errors++; $display("FAIL serial_q got %h exp B2", q); end
    checks++; if (q0 !== 8'h4D) begin errors++; $display("FAIL serial_q0 got %h exp 4D", q0); end
    op(1'b1, 3'b000, 8'h00, 1'b0);
    checks++; if (word_done !== 1'b0) begin errors++; $display("FAIL serial_done_drop got %b exp 0", word_done); end
  endtask

  task automatic test_rotate;
    op(1'b1, 3'b001, 8'h81, 1'b0);
    op(1'b1, 3'b101, 8'h00, 1'b0);
    checks++; if ({q, sout, cnt} !== {8'hC0, 1'b1, 3'd1})
      begin errors++; $display("FAIL ror got q=%h sout=%b cnt=%0d exp C0/1/1", q, sout, cnt); end
    op(1'b1, 3'b100, 8'h00, 1'b0);
    checks++; if ({q, sout, cnt} !== {8'h81, 1'b1, 3'd2})
      begin errors++; $display("FAIL rol1 got q=%h sout=%b cnt=%0d exp 81/1/2", q, sout, cnt); end
    op(1'b1, 3'b100, 8'h00, 1'b0);
    checks++; if ({q, sout, cnt} !== {8'h03, 1'b1, 3'd3})
      begin errors++; $display("FAIL rol2 got q=%h sout=%b cnt=%0d exp 03/1/3", q, sout, cnt); end
    // shr of 03 with sin=0 -> 01, sout=1
    op(1'b1, 3'b011, 8'h00, 1'b0);
    checks++; if ({q, sout} !== {8'h01, 1'b1})
      begin errors++; $display("FAIL shr got q=%h sout=%b exp 01/1", q, sout); end
    // sout must hold through load and clear
    op(1'b1, 3'b001, 8'h00, 1'b0);
    checks++; if (sout !== 1'b1) begin errors++; $display("FAIL sout_load got %b exp 1", sout); end
    op(1'b1, 3'b110, 8'h00, 1'b0);
    checks++; if (sout !== 1'b1) begin errors++; $display("FAIL sout_clear got %b exp 1", sout); end
  endtask

  task automatic test_abort_clear;
    int pulses;
    op(1'b1, 3'b001, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) op(1'b1, 3'b010, 8'h00, 1'b1);
    op(1'b1, 3'b110, 8'h00, 1'b0);
    checks++; if ({q, cnt, word_done} !== {8'h00, 3'd0, 1'b0})
      begin errors++; $display("FAIL clear_abort got q=%h cnt=%0d done=%b exp 00/0/0", q, cnt, word_done); end
    pulses = 0;
    for (int i = 0; i < 7; i++) begin
      op(1'b1, 3'b011, 8'h00, 1'b1);
      if (word_done) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL clear_7shifts pulses got %0d exp 0", pulses); end
    op(1'b1, 3'b100, 8'h00, 1'b0);
    checks++; if ({cnt, word_done} !== {3'd0, 1'b1})
      begin errors++; $display("FAIL clear_8th got cnt=%0d done=%b exp 0/1", cnt, word_done); end
  endtask

  task automatic test_abort_reset;
    int pulses;
    op(1'b1, 3'b001, 8'h00, 1'b0);
    for (int i = 0; i < 6; i++) op(1'b1, 3'b010, 8'h00, 1'b1);
    reset = 1'b1;
    op(1'b1, 3'b010, 8'h00, 1'b1);
    reset = 1'b0;
    checks++; if ({q, cnt, word_done} !== {8'h00, 3'd0, 1'b0})
      begin errors++; $display("FAIL reset_abort got q=%h cnt=%0d done=%b exp 00/0/0", q, cnt, word_done); end
    pulses = 0;
    for (int i = 0; i < 7; i++) begin
      op(1'b1, 3'b101, 8'h00, 1'b0);
      if (word_done) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL reset_7shifts pulses got %0d exp 0", pulses); end
  endtask

  task automatic test_load_at_boundary;
    op(1'b1, 3'b001, 8'h00, 1'b0);
    for (int i = 0; i < 7; i++) op(1'b1, 3'b010, 8'h00, 1'b1);
    checks++; if (cnt !== 3'd7) begin errors++; $display("FAIL boundary_pre cnt got %0d exp 7", cnt); end
    op(1'b1, 3'b001, 8'h5A, 1'b0);
    checks++; if ({q, cnt, word_done} !== {8'h5A, 3'd0, 1'b0})
      begin errors++; $display("FAIL boundary_load got q=%h cnt=%0d done=%b exp 5A/0/0", q, cnt, word_done); end
  endtask

  task automatic test_invert_parity;
    op(1'b1, 3'b001, 8'h07, 1'b0);
    checks++; if (par !== PAR_ON) begin errors++; $display("FAIL par_load got %b exp %b", par, PAR_ON); end
    op(1'b1, 3'b111, 8'h00, 1'b0);
    checks++; if ({q, q0, cnt} !== {8'hF8, 8'h07, 3'd0})
      begin errors++; $display("FAIL invert got q=%h q0=%h cnt=%0d exp F8/07/0", q, q0, cnt); end
    checks++; if (par !== PAR_ON) begin errors++; $display("FAIL par_inv got %b exp %b", par, PAR_ON); end
    // F8 >> 3 with sin=0 -> 1F, cnt=3; invert keeps cnt
    for (int i = 0; i < 3; i++) op(1'b1, 3'b011, 8'h00, 1'b0);
    op(1'b1, 3'b111, 8'h00, 1'b0);
    checks++; if ({q, q0, cnt} !== {8'hE0, 8'h1F, 3'd3})
      begin errors++; $display("FAIL invert_cnt got q=%h q0=%h cnt=%0d exp E0/1F/3", q, q0, cnt); end
    // 0x0F has even weight: parity 0 regardless of the build
    op(1'b1, 3'b001, 8'h0F, 1'b0);
    checks++; if (par !== 1'b0) begin errors++; $display("FAIL par_even got %b exp 0", par); end
    op(1'b1, 3'b001, 8'h01, 1'b0);
    checks++; if (par !== PAR_ON) begin errors++; $display("FAIL par_odd got %b exp %b", par, PAR_ON); end
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; mode = 3'b000; d = '0; sin = 1'b0;
    @(negedge clk);
    test_reset;
    test_load_enable;
    test_serial_word;
    test_rotate;
    test_abort_clear;
    test_abort_reset;
    test_load_at_boundary;
    test_invert_parity;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
